// File: rtl/dsp_mac_sequencer.sv
// Sequences MAC jobs onto a pipelined DSP slice: issues operand beats, drains the
// slice latency, and hands back the accumulated result. Optional: DSP_SEQ_CHAIN_EN.
module dsp_mac_sequencer #(
  parameter int SLICE_LAT = 3,
  parameter int LEN_W     = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [LEN_W-1:0] job_len,
  input  logic             job_const,
  input  logic             job_neg,
  input  logic [2:0]       job_coef,
`ifdef DSP_SEQ_CHAIN_EN
  input  logic             job_chain,
`endif
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [26:0]      in_ax,
  input  logic [26:0]      in_ay,
  input  logic [25:0]      in_az,
  output logic             dsp_ena,
  output logic             dsp_loadconst,
  output logic             dsp_accumulate,
  output logic             dsp_negate,
  output logic [26:0]      dsp_ax,
  output logic [26:0]      dsp_ay,
  output logic [25:0]      dsp_az,
  output logic [2:0]       dsp_coefsela,
  output logic [4:0]       dsp_mux_sel,
  input  logic [63:0]      dsp_resulta,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [63:0]      res_data
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam int LAT_W = (SLICE_LAT > 1) ? $clog2(SLICE_LAT) : 1;

  logic [1:0]       r_state;
  logic [LEN_W-1:0] r_cnt;
  logic [LAT_W-1:0] r_lat;
  logic             r_first;
  logic             r_const;
  logic             r_neg;
  logic [2:0]       r_coef;
  logic [63:0]      r_res;
`ifdef DSP_SEQ_CHAIN_EN
  logic             r_chain;
`endif

  logic w_acc;
  assign w_acc = (r_state == S_RUN) && in_valid;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_lat   <= '0;
      r_first <= 1'b0;
      r_const <= 1'b0;
      r_neg   <= 1'b0;
      r_coef  <= '0;
      r_res   <= '0;
`ifdef DSP_SEQ_CHAIN_EN
      r_chain <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_const <= job_const;
          r_neg   <= job_neg;
          r_coef  <= job_coef;
`ifdef DSP_SEQ_CHAIN_EN
          r_chain <= job_chain;
`endif
          r_cnt   <= job_len;
          r_first <= 1'b1;
          if (job_len == '0) begin
            r_res   <= '0;
            r_state <= S_DONE;
          end else begin
            r_state <= S_RUN;
          end
        end
        S_RUN: if (w_acc) begin
          // counter moves only on accepted beats; bubbles leave it alone
          r_cnt   <= r_cnt - LEN_W'(1);
          r_first <= 1'b0;
          if (r_cnt == LEN_W'(1)) begin
            r_lat   <= LAT_W'(SLICE_LAT - 1);
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (r_lat == '0) begin
            r_res   <= dsp_resulta;
            r_state <= S_DONE;
          end else begin
            r_lat <= r_lat - LAT_W'(1);
          end
        end
        default: if (res_ready) r_state <= S_IDLE;
      endcase
    end
  end

  // Issue path is combinational so the last beat lands exactly SLICE_LAT edges before capture.
  always_comb begin
    busy           = (r_state != S_IDLE);
    in_ready       = (r_state == S_RUN);
    dsp_ena        = (r_state == S_RUN) || (r_state == S_DRAIN);
    dsp_ax         = w_acc ? in_ax : '0;
    dsp_ay         = w_acc ? in_ay : '0;
    dsp_az         = w_acc ? in_az : '0;
    dsp_accumulate = dsp_ena && !(w_acc && r_first);
    dsp_loadconst  = w_acc && r_first && r_const;
    dsp_negate     = busy && r_neg;
    dsp_coefsela   = busy ? r_coef : 3'd0;
`ifdef DSP_SEQ_CHAIN_EN
    dsp_mux_sel    = (busy && r_chain) ? 5'b11111 : 5'b01111;
`else
    dsp_mux_sel    = 5'b01111;
`endif
    res_valid      = (r_state == S_DONE);
    res_data       = r_res;
  end
endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Scoreboard bench for dsp_mac_sequencer with a behavioural slice model driving dsp_resulta.
module tb_dsp_mac_sequencer;
  logic        clk = 1'b0;
  logic        clr, start, job_const, job_neg, in_valid, res_ready;
  logic [7:0]  job_len;
  logic [2:0]  job_coef;
  logic [26:0] in_ax, in_ay;
  logic [25:0] in_az;
  logic        busy, in_ready, dsp_ena, dsp_loadconst, dsp_accumulate, dsp_negate, res_valid;
  logic [26:0] dsp_ax, dsp_ay;
  logic [25:0] dsp_az;
  logic [2:0]  dsp_coefsela;
  logic [4:0]  dsp_mux_sel;
  logic [63:0] dsp_resulta, res_data;
`ifdef DSP_SEQ_CHAIN_EN
  logic        job_chain;
  localparam logic [4:0] BUSY_MUX = 5'b11111;
`else
  localparam logic [4:0] BUSY_MUX = 5'b01111;
`endif

  dsp_mac_sequencer #(.SLICE_LAT(3), .LEN_W(8)) dut (
    .clk(clk), .clr(clr), .start(start), .job_len(job_len), .job_const(job_const),
    .job_neg(job_neg), .job_coef(job_coef),
`ifdef DSP_SEQ_CHAIN_EN
    .job_chain(job_chain),
`endif
    .busy(busy), .in_valid(in_valid), .in_ready(in_ready), .in_ax(in_ax), .in_ay(in_ay),
    .in_az(in_az), .dsp_ena(dsp_ena), .dsp_loadconst(dsp_loadconst),
    .dsp_accumulate(dsp_accumulate), .dsp_negate(dsp_negate), .dsp_ax(dsp_ax),
    .dsp_ay(dsp_ay), .dsp_az(dsp_az), .dsp_coefsela(dsp_coefsela), .dsp_mux_sel(dsp_mux_sel),
    .dsp_resulta(dsp_resulta), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
  );

  always #5 clk = ~clk;

  // Slice model: accumulator plus two delay stages gives a 3-cycle issue-to-result latency.
  logic [63:0] m_acc = '0, m_p1 = '0, m_p2 = '0;
  assign dsp_resulta = m_p2;
  always @(posedge clk) begin
    logic [63:0] prod, base;
    prod = 64'(dsp_ax) * 64'(dsp_ay) + 64'(dsp_az);
    base = dsp_loadconst ? 64'd100 : (dsp_accumulate ? m_acc : 64'd0);
    if (dsp_ena) m_acc <= dsp_negate ? base - prod : base + prod;
    m_p1 <= m_acc;
    m_p2 <= m_p1;
  end

  int checks = 0, failures = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  logic [63:0] exp_q[$];
  int n_acc, n_lc, n_neg, n_ena, n_rv, n_mux_bad;
  always @(negedge clk) begin
    if (in_valid && in_ready) begin
      n_acc++;
      if (dsp_loadconst) n_lc++;
      if (dsp_negate) n_neg++;
    end
    if (dsp_ena) n_ena++;
    if (res_valid) n_rv++;
    if (dsp_mux_sel !== (busy ? BUSY_MUX : 5'b01111)) n_mux_bad++;
  end

  // Monitor: pops an expectation for every result handshake.
  always @(negedge clk) begin
    if (res_valid && res_ready) begin
      if (exp_q.size() == 0) chk("unexpected_result", res_data, 64'hdead);
      else chk("res_data", res_data, exp_q.pop_front());
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask
  task automatic clear_cnt(); n_acc = 0; n_lc = 0; n_neg = 0; n_ena = 0; n_rv = 0; endtask

  task automatic go(input logic [7:0] len, input logic c, input logic n, input logic [2:0] coef,
                    input logic [63:0] exp);
    exp_q.push_back(exp);
    start = 1; job_len = len; job_const = c; job_neg = n; job_coef = coef;
    tick();
    start = 0;
  endtask

  task automatic beat(input logic [26:0] ax, input logic [26:0] ay, input logic [25:0] az);
    in_valid = 1; in_ax = ax; in_ay = ay; in_az = az;
    tick();
    in_valid = 0; in_ax = '0; in_ay = '0; in_az = '0;
  endtask

  // Waits for res_valid, holds off ready two cycles, then handshakes with a start that must be ignored.
  task automatic take_result(input string name);
    int k = 0;
    logic [63:0] held;
    while (!res_valid && k < 30) begin tick(); k++; end
    if (!res_valid) chk({name, "_timeout"}, 0, 1);
    held = res_data;
    tick(); tick();
    chk({name, "_held_valid"}, res_valid, 1);
    chk({name, "_held_data"}, res_data, held);
    res_ready = 1; start = 1; job_len = 8'd1;
    tick();
    res_ready = 0; start = 0;
    @(negedge clk);
    chk({name, "_back_idle"}, busy, 0);
    tick();
  endtask

  initial begin
    clr = 1; start = 0; job_len = 0; job_const = 0; job_neg = 0; job_coef = 0;
    in_valid = 0; in_ax = 0; in_ay = 0; in_az = 0; res_ready = 0;
`ifdef DSP_SEQ_CHAIN_EN
    job_chain = 1;
`endif
    tick(); tick();
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_outs", {in_ready, dsp_ena, dsp_loadconst, dsp_accumulate, dsp_negate, res_valid}, 0);
    chk("rst_data", {dsp_ax, dsp_ay, dsp_az, dsp_coefsela}, 0);
    chk("rst_res", res_data, 0);
    chk("rst_mux", dsp_mux_sel, 5'b01111);
    clr = 0;
    tick();

    // single beat: 1*2+3
    clear_cnt();
    go(8'd1, 0, 0, 3'd2, 64'd5);
    in_valid = 1; in_ax = 1; in_ay = 2; in_az = 3;
    @(negedge clk);
    chk("j1_first_acc", dsp_accumulate, 0);
    tick();
    in_valid = 0; in_ax = 0; in_ay = 0; in_az = 0;
    repeat (2) tick();
    @(negedge clk);
    chk("j1_drain3_not_done", res_valid, 0);
    tick();
    @(negedge clk);
    chk("j1_done", res_valid, 1);
    take_result("j1");
    chk("j1_beats", n_acc, 1);
    chk("j1_ena_cycles", n_ena, 4);

    // four beats with bubbles: 2+10+30+7
    clear_cnt();
    go(8'd4, 0, 0, 3'd1, 64'd49);
    beat(1, 1, 1);
    @(negedge clk);
    chk("j2_bubble_ops", {dsp_ax, dsp_ay, dsp_az}, 0);
    chk("j2_bubble_acc", dsp_accumulate, 1);
    tick();
    beat(2, 3, 4);
    tick();
    beat(5, 5, 5);
    beat(1, 0, 7);
    @(negedge clk);
    chk("j2_drain_entered", {busy, in_ready}, 2'b10);
    take_result("j2");
    chk("j2_beats", n_acc, 4);

    // const + negate: 100-7-4
    clear_cnt();
    go(8'd2, 1, 1, 3'd5, 64'd89);
    in_valid = 1; in_ax = 2; in_ay = 3; in_az = 1;
    @(negedge clk);
    chk("j3_coef", dsp_coefsela, 5);
    tick();
    in_valid = 0;
    beat(4, 1, 0);
    take_result("j3");
    chk("j3_loadconst_cnt", n_lc, 1);
    chk("j3_negate_cnt", n_neg, 2);

    // zero-length job
    clear_cnt();
    go(8'd0, 0, 0, 3'd0, 64'd0);
    @(negedge clk);
    chk("j4_done_next", res_valid, 1);
    take_result("j4");
    chk("j4_no_ena", n_ena, 0);

    // clear mid-job
    clear_cnt();
    go(8'd5, 0, 0, 3'd7, 64'd0);
    beat(1, 1, 1);
    in_valid = 1; in_ax = 9; in_ay = 9; in_az = 9; clr = 1;
    tick();
    in_valid = 0; clr = 0;
    @(negedge clk);
    chk("clr_busy", busy, 0);
    chk("clr_outs", {in_ready, dsp_ena, dsp_loadconst, dsp_accumulate, dsp_negate, dsp_coefsela}, 0);
    void'(exp_q.pop_back());
    repeat (6) tick();
    chk("clr_no_result", n_rv, 0);

    clear_cnt();
    go(8'd1, 0, 0, 3'd3, 64'd9);
    beat(3, 3, 0);
    take_result("j5");
    chk("mux_sel", n_mux_bad, 0);
    chk("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
